// File: rtl/oam_dma_ctrl_if.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl_if
// Bundles the CPU-side and memory-side bus of the OAM DMA controller.
//   cpu_read/cpu_write/cpu_address/cpu_wdata : CPU request
//   cpu_rdata/cpu_resp/cpu_stall             : CPU response and stall
//   mem_read/mem_write_n/mem_address/mem_wdata : memory request (write active-low)
//   mem_rdata/mem_resp                       : memory response (rdata combinational)
// Modports: slave = controller side, master = CPU/memory environment side.
// ---------------------------------------------------------------------------
interface oam_dma_ctrl_if;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_resp;
    logic        cpu_stall;
    logic        mem_read;
    logic        mem_write_n;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_resp;

    modport slave (
        input  cpu_read, cpu_write, cpu_address, cpu_wdata, mem_rdata, mem_resp,
        output cpu_rdata, cpu_resp, cpu_stall,
        output mem_read, mem_write_n, mem_address, mem_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_address, cpu_wdata, mem_rdata, mem_resp,
        input  cpu_rdata, cpu_resp, cpu_stall,
        input  mem_read, mem_write_n, mem_address, mem_wdata
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// oam_dma_ctrl
// Shares a single memory port between the CPU and a sprite DMA engine.
// A CPU write to DMA_REG_ADDR stalls the CPU and copies XFER_LEN bytes from
// page {wdata,8'h00} to OAM_DATA_ADDR (read/write pairs). Otherwise the CPU
// bus passes straight through to memory.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : CPU + memory bus (oam_dma_ctrl_if.slave)
//   dma_active : DMA owns the memory port
//   dma_done   : one-cycle pulse after the last OAM write
// ---------------------------------------------------------------------------
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int unsigned XFER_LEN      = 256
) (
    input  logic          clk,
    input  logic          rst,
    oam_dma_ctrl_if.slave bus,
    output logic          dma_active,
    output logic          dma_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_ALIGN2, S_READ, S_WRITE, S_DONE
    } state_t;

    localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

    state_t     state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] rdata_q, rdata_d;
    logic       parity_q;
    logic       trigger;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            page_q   <= '0;
            idx_q    <= '0;
            byte_q   <= '0;
            rdata_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            byte_q   <= byte_d;
            rdata_q  <= rdata_d;
            parity_q <= ~parity_q;
        end
    end

    assign trigger = bus.cpu_write && (bus.cpu_address == DMA_REG_ADDR);

    always_comb begin
        state_d         = state_q;
        page_d          = page_q;
        idx_d           = idx_q;
        byte_d          = byte_q;
        rdata_d         = rdata_q;
        bus.cpu_rdata   = rdata_q;
        bus.cpu_resp    = 1'b0;
        bus.cpu_stall   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write_n = 1'b1;
        bus.mem_address = {page_q, idx_q};
        bus.mem_wdata   = byte_q;
        dma_active      = 1'b0;
        dma_done        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bus.cpu_rdata   = bus.mem_rdata;
                bus.cpu_resp    = bus.mem_resp;
                bus.mem_address = bus.cpu_address;
                bus.mem_wdata   = bus.cpu_wdata;
                // Keep a copy so cpu_rdata holds steady while stalled.
                rdata_d         = bus.mem_rdata;
                if (trigger) begin
                    // Register write is absorbed; any concurrent read is dropped.
                    page_d       = bus.cpu_wdata;
                    bus.cpu_resp = 1'b1;
                    state_d      = S_ALIGN;
                end else begin
                    bus.mem_read    = bus.cpu_read;
                    bus.mem_write_n = ~bus.cpu_write;
                end
            end
            S_ALIGN: begin
                bus.cpu_stall = 1'b1;
                dma_active    = 1'b1;
                // Odd get/put phase needs one extra idle cycle.
                state_d       = parity_q ? S_ALIGN2 : S_READ;
            end
            S_ALIGN2: begin
                bus.cpu_stall = 1'b1;
                dma_active    = 1'b1;
                state_d       = S_READ;
            end
            S_READ: begin
                bus.cpu_stall = 1'b1;
                dma_active    = 1'b1;
                bus.mem_read  = 1'b1;
                byte_d        = bus.mem_rdata;
                state_d       = S_WRITE;
            end
            S_WRITE: begin
                bus.cpu_stall   = 1'b1;
                dma_active      = 1'b1;
                bus.mem_write_n = 1'b0;
                bus.mem_address = OAM_DATA_ADDR;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                bus.cpu_stall = 1'b1;
                dma_done      = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes drop the instant reset rises, even if the CPU is writing.
        if (rst) begin
            bus.mem_write_n = 1'b1;
            bus.mem_read    = 1'b0;
        end
    end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_oam_dma_ctrl
// Directed testbench for oam_dma_ctrl: passthrough, even/odd aligned DMA,
// page $FF, retrigger while stalled, and reset in the middle of a transfer.
// ---------------------------------------------------------------------------
module tb_oam_dma_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic dma_active, dma_done;

    always #5 clk = ~clk;

    oam_dma_ctrl_if bus ();

    oam_dma_ctrl #(
        .DMA_REG_ADDR (16'h4014),
        .OAM_DATA_ADDR(16'h2004),
        .XFER_LEN     (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dma_active(dma_active),
        .dma_done  (dma_done)
    );

    // Memory model: combinational read, write on rising edge while write_n low.
    // $4014 reads back a fixed open-bus value.
    logic [7:0] mem [65536];
    assign bus.mem_rdata = (bus.mem_address == 16'h4014) ? 8'h3C : mem[bus.mem_address];
    assign bus.mem_resp  = bus.mem_read | ~bus.mem_write_n;
    always @(posedge clk) if (!bus.mem_write_n) mem[bus.mem_address] = bus.mem_wdata;

    // Reference get/put phase: cleared by reset, toggles every cycle.
    logic par_m;
    always @(posedge clk or posedge rst) if (rst) par_m <= 1'b0; else par_m <= ~par_m;

    // Bus monitor, sampled on the falling edge.
    int         stall_n = 0, done_n = 0, rd_n = 0, pagebad_n = 0;
    int         w4014_n = 0, oam_n = 0, wl_n = 0;
    logic [15:0] last_rd = '0;
    logic [7:0]  oam_d [2048];
    logic [7:0]  exp_page = '0;

    always @(negedge clk) begin
        if (bus.cpu_stall) stall_n++;
        if (dma_done) done_n++;
        if (bus.mem_read && dma_active) begin
            rd_n++;
            last_rd = bus.mem_address;
            if (bus.mem_address[15:8] != exp_page) pagebad_n++;
        end
        if (!bus.mem_write_n) begin
            wl_n++;
            if (bus.mem_address == 16'h2004) begin
                if (oam_n < 2048) oam_d[oam_n] = bus.mem_wdata;
                oam_n++;
            end
            if (bus.mem_address == 16'h4014) w4014_n++;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_write   = 1'b1;
        bus.cpu_address = a;
        bus.cpu_wdata   = d;
        cyc();
        bus.cpu_write   = 1'b0;
    endtask

    task automatic wait_par(input logic p);
        for (int i = 0; i < 4 && par_m != p; i++) cyc();
    endtask

    task automatic trigger(input string nm, input logic [7:0] pg, input logic p);
        wait_par(p);
        exp_page        = pg;
        bus.cpu_write   = 1'b1;
        bus.cpu_read    = 1'b1;
        bus.cpu_address = 16'h4014;
        bus.cpu_wdata   = pg;
        #1;
        check({nm, "_trig_resp"}, bus.cpu_resp, 1);
        check({nm, "_trig_wr_n"}, bus.mem_write_n, 1);
        check({nm, "_trig_rd"}, bus.mem_read, 0);
        check({nm, "_trig_stall"}, bus.cpu_stall, 0);
        cyc();
        bus.cpu_write = 1'b0;
        bus.cpu_read  = 1'b0;
    endtask

    task automatic run_dma(input string nm, input logic [7:0] pg, input logic [7:0] pat,
                           input logic p, input int exp_stall, input bit retrig);
        int s_stall, s_done, s_rd, s_bad, s_w, s_oam, bad;
        bit seen;
        s_stall = stall_n; s_done = done_n; s_rd = rd_n; s_bad = pagebad_n;
        s_w = w4014_n; s_oam = oam_n;
        trigger(nm, pg, p);
        seen = 0;
        for (int k = 0; k < 700 && !seen; k++) begin
            if (retrig && k == 50) begin
                bus.cpu_write   = 1'b1;
                bus.cpu_address = 16'h4014;
                bus.cpu_wdata   = 8'h03;
                #1;
                check({nm, "_mid_stall"}, bus.cpu_stall, 1);
                check({nm, "_mid_resp"}, bus.cpu_resp, 0);
                check({nm, "_mid_rdata"}, bus.cpu_rdata, 8'h3C);
            end
            if (retrig && k == 51) bus.cpu_write = 1'b0;
            cyc();
            if (done_n != s_done) seen = 1;
        end
        check({nm, "_done_seen"}, seen, 1);
        cyc();
        cyc();
        check({nm, "_stall_cycles"}, stall_n - s_stall, exp_stall);
        check({nm, "_done_pulses"}, done_n - s_done, 1);
        check({nm, "_reads"}, rd_n - s_rd, 256);
        check({nm, "_page_off"}, pagebad_n - s_bad, 0);
        check({nm, "_w4014"}, w4014_n - s_w, 0);
        check({nm, "_oam_writes"}, oam_n - s_oam, 256);
        check({nm, "_last_rd"}, last_rd, {pg, 8'hFF});
        check({nm, "_first_data"}, oam_d[s_oam], pat);
        check({nm, "_last_data"}, oam_d[s_oam + 255], pat ^ 8'hFF);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (oam_d[s_oam + i] !== (8'(i) ^ pat)) bad++;
        check({nm, "_data_errs"}, bad, 0);
        check({nm, "_stall_after"}, bus.cpu_stall, 0);
        check({nm, "_active_after"}, dma_active, 0);
    endtask

    initial begin
        int s_wl, s_oam;
        bit hit;
        rst             = 1'b1;
        bus.cpu_read    = 1'b0;
        bus.cpu_write   = 1'b1;
        bus.cpu_address = 16'h0300;
        bus.cpu_wdata   = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall", bus.cpu_stall, 0);
        check("rst_active", dma_active, 0);
        check("rst_done", dma_done, 0);
        check("rst_wr_gated", bus.mem_write_n, 1);
        check("rst_rd", bus.mem_read, 0);
        bus.cpu_write = 1'b0;
        rst = 1'b0;
        cyc();

        // Passthrough write then read.
        s_wl = wl_n;
        bus.cpu_write   = 1'b1;
        bus.cpu_address = 16'h0300;
        bus.cpu_wdata   = 8'h55;
        #1;
        check("pt_wr_n", bus.mem_write_n, 0);
        check("pt_wr_addr", bus.mem_address, 16'h0300);
        cyc();
        bus.cpu_write = 1'b0;
        bus.cpu_read  = 1'b1;
        #1;
        check("pt_rdata", bus.cpu_rdata, 8'h55);
        check("pt_resp", bus.cpu_resp, 1);
        check("pt_rd", bus.mem_read, 1);
        check("pt_stall", bus.cpu_stall, 0);
        cyc();
        bus.cpu_read = 1'b0;
        check("pt_wr_cycles", wl_n - s_wl, 1);

        // Source pages loaded through the passthrough path.
        for (int i = 0; i < 256; i++) cpu_wr({8'h02, 8'(i)}, 8'(i) ^ 8'hA5);
        for (int i = 0; i < 256; i++) cpu_wr({8'hFF, 8'(i)}, 8'(i) ^ 8'h5A);
        cyc();

        run_dma("even",   8'h02, 8'hA5, 1'b1, 514, 1'b0);
        run_dma("odd",    8'h02, 8'hA5, 1'b0, 515, 1'b0);
        run_dma("pgff",   8'hFF, 8'h5A, 1'b1, 514, 1'b0);
        run_dma("retrig", 8'h02, 8'hA5, 1'b1, 514, 1'b1);

        // Reset during the WRITE of byte 100.
        s_oam = oam_n;
        trigger("rstmid", 8'h02, 1'b1);
        hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            cyc();
            if (!bus.mem_write_n && (oam_n - s_oam) == 100) hit = 1;
        end
        check("rstmid_reached", hit, 1);
        rst = 1'b1;
        #1;
        check("rstmid_wr_n", bus.mem_write_n, 1);
        check("rstmid_stall", bus.cpu_stall, 0);
        check("rstmid_active", dma_active, 0);
        cyc();
        cyc();
        rst = 1'b0;
        repeat (5) cyc();
        check("rstmid_oam_writes", oam_n - s_oam, 100);
        check("rstmid_stall_idle", bus.cpu_stall, 0);
        run_dma("rerun", 8'h02, 8'hA5, 1'b1, 514, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
